// File: rtl/score_to_ascii.sv
// Binary score to two-digit ASCII converter using repeated subtraction, driving a text RAM load port.
// Optional macro SCORE_LEADING_BLANK_EN blanks a leading zero tens digit.
module score_to_ascii #(
   parameter int VALUE_W   = 7,
   parameter int MAX_VALUE = 99
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [VALUE_W-1:0] value,
   output logic               busy,
   output logic               load_text,
   output logic [13:0]        text_out,
   output logic               ovf
);

   typedef enum logic [1:0] {IDLE, CONVERT, EMIT} state_t;

   localparam logic [VALUE_W-1:0] MAX_V = VALUE_W'(MAX_VALUE);
   localparam logic [VALUE_W-1:0] TEN   = VALUE_W'(10);

   state_t             state;
   logic [VALUE_W-1:0] rem;
   logic [3:0]         tens;
   logic               ovf_next;
   logic [6:0]         tens_char;
   logic [6:0]         units_char;

   // NOTE: always_comb assigns every output before any conditional override, so no latch is inferred.
   always_comb begin
      tens_char  = 7'h30 + {3'b000, tens};
      units_char = 7'h30 + {3'b000, rem[3:0]};
`ifdef SCORE_LEADING_BLANK_EN
      if (tens == 4'd0) tens_char = 7'h20;
`endif
   end

   assign busy = (state != IDLE);

   // text_out and load_text update on the edge that leaves EMIT, so the strobe and data arrive together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         // NOTE: datapath registers are reset too, so a discarded conversion leaves no stale state behind.
         rem       <= '0;
         tens      <= '0;
         ovf_next  <= 1'b0;
         load_text <= 1'b0;
         ovf       <= 1'b0;
         text_out  <= {7'h20, 7'h20};
      end else begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values within this block.
         load_text <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rem      <= (value > MAX_V) ? MAX_V : value;
                  tens     <= 4'd0;
                  ovf_next <= (value > MAX_V);
                  state    <= CONVERT;
               end
            end
            CONVERT: begin
               if (rem >= TEN) begin
                  rem  <= rem - TEN;
                  tens <= tens + 4'd1;
               end else begin
                  state <= EMIT;
               end
            end
            EMIT: begin
               text_out  <= {tens_char, units_char};
               ovf       <= ovf_next;
               load_text <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
